// File: rtl/efx_cdc_handshake_rx.sv
// -----------------------------------------------------------------------------
// efx_cdc_handshake_rx
//
// Destination-side endpoint of a 4-phase req/ack clock-domain crossing that
// carries one multi-bit word per handshake. The asynchronous request is passed
// through a STAGE-flop synchronizer. The sender-held data bus is captured once,
// on the edge that accepts the request. The word is then offered on a
// valid/ready interface, and the acknowledge is returned to the source domain
// from a single flop, so it cannot glitch.
//
// Parameters
//   WIDTH      data word width
//   STAGE      request synchronizer depth (>= 2)
//   ACK_EARLY  0: ack rises after the consumer takes the word
//              1: ack rises at capture; the word is buffered locally, so the
//                 sender may finish its handshake before the consumer is ready
//   CNT_W      width of the accepted-word counter
//
// Ports
//   clk_i         destination clock (the only clock in this block)
//   rst_n         asynchronous active-low reset
//   req_async_i   request from the source domain, unsynchronized
//   data_async_i  data from the source domain, held stable by the sender
//                 until it sees ack
//   ack_o         acknowledge back to the source domain (registered)
//   data_o        captured word
//   valid_o       data_o holds a word that has not been consumed yet
//   ready_i       consumer accepts the word when valid_o & ready_i
//   busy_o        a transfer is in progress (state is not IDLE)
//   rx_count_o    number of accepted words, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module efx_cdc_handshake_rx #(
    parameter int WIDTH     = 32,
    parameter int STAGE     = 2,
    parameter int ACK_EARLY = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             req_async_i,
    input  logic [WIDTH-1:0] data_async_i,
    output logic             ack_o,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] rx_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // waiting for a request
        ST_HOLD    = 2'd1,  // word captured, waiting for the consumer
        ST_RELEASE = 2'd2   // word consumed, ack high, waiting for req to drop
    } state_e;

    localparam bit EARLY = (ACK_EARLY != 0);

    logic [STAGE-1:0] sync_q;
    logic             req_s;

    state_e           state_q, state_d;
    logic             ack_q,   ack_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // Request synchronizer. This is the only logic that samples req_async_i.
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // updates from the values present before the edge, so each shift stage
    // moves by exactly one position per clock.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGE-2:0], req_async_i};
        end
    end

    assign req_s = sync_q[STAGE-1];

    // Next-state logic. data_async_i is read only in the IDLE capture branch.
    // By then req_s has passed through the synchronizer, and the sender has
    // held the bus stable since before it raised req.
    always_comb begin
        // NOTE: every _d signal takes its current value first. Each path
        // therefore assigns every output, which keeps this block free of
        // inferred latches.
        state_d = state_q;
        ack_d   = ack_q;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    data_d  = data_async_i;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                    if (EARLY) begin
                        ack_d = 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (valid_q && ready_i) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (!EARLY) begin
                        ack_d   = 1'b1;
                        state_d = ST_RELEASE;
                    end else begin
                        // ack still high: the sender has not dropped req yet,
                        // so finish its handshake before taking another word.
                        state_d = ack_q ? ST_RELEASE : ST_IDLE;
                    end
                end else if (EARLY && ack_q && !req_s) begin
                    // The sender has finished its half of the handshake while
                    // the buffered word is still waiting for the consumer.
                    ack_d = 1'b0;
                end
            end

            ST_RELEASE: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ack_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            // NOTE: the wide data register is reset along with the control
            // flops. data_o must read zero out of reset, not whatever was
            // captured before reset.
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ack_o      = ack_q;
    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign rx_count_o = cnt_q;

endmodule
